// File: rtl/vga_frame_source.sv
// 640x480@60 raster generator with clock-enable pixel divider and a
// frame-synchronous shadow register for the renderer's 48-bit digit word.
module vga_frame_source #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] numbers_in,
  input  logic        numbers_wr,
  output logic [47:0] numbers_concat,
  output logic        numbers_ack,
  output logic        numbers_pending,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pix_tick,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_tick;
  logic [9:0]       r_sx, r_sy;
  logic             r_hsync, r_vsync, r_de;
  logic             r_frame_start;
  logic [47:0]      r_pend_word, r_concat;
  logic             r_pending, r_ack;

  logic             w_line_end, w_wrap;
  logic [9:0]       w_sx_next, w_sy_next;

  always_comb begin
    w_line_end = r_pix_tick && (r_sx == H_LAST);
    w_wrap     = w_line_end && (r_sy == V_LAST);
    w_sx_next  = w_line_end ? '0 : r_sx + 10'd1;
    if (w_wrap)          w_sy_next = '0;
    else if (w_line_end) w_sy_next = r_sy + 10'd1;
    else                 w_sy_next = r_sy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_pix_tick    <= 1'b0;
      r_sx          <= '0;
      r_sy          <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b1;
      r_frame_start <= 1'b0;
      r_pend_word   <= '0;
      r_concat      <= '0;
      r_pending     <= 1'b0;
      r_ack         <= 1'b0;
    end else begin
      r_div         <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_pix_tick    <= (r_div == DIV_LAST);
      r_frame_start <= w_wrap;

      // Sync/de decode the next coordinates so they land with sx/sy, no skew.
      if (r_pix_tick) begin
        r_sx    <= w_sx_next;
        r_sy    <= w_sy_next;
        r_hsync <= !((w_sx_next >= HS_START) && (w_sx_next < HS_END));
        r_vsync <= !((w_sy_next >= VS_START) && (w_sy_next < VS_END));
        r_de    <= (w_sx_next < H_VIS) && (w_sy_next < V_VIS);
      end

      // A write landing on the wrap edge bypasses the pending register.
      r_ack <= 1'b0;
      if (w_wrap && (numbers_wr || r_pending)) begin
        r_concat  <= numbers_wr ? numbers_in : r_pend_word;
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
      end else if (numbers_wr) begin
        r_pend_word <= numbers_in;
        r_pending   <= 1'b1;
      end
    end
  end

  assign numbers_concat  = r_concat;
  assign numbers_ack     = r_ack;
  assign numbers_pending = r_pending;
  assign sx              = r_sx;
  assign sy              = r_sy;
  assign hsync           = r_hsync;
  assign vsync           = r_vsync;
  assign de              = r_de;
  assign pix_tick        = r_pix_tick;
  assign frame_start     = r_frame_start;

endmodule

// File: tb/tb_vga_frame_source.sv
// Bench for vga_frame_source: two instances (CLK_DIV=3 and 1) on a shrunken
// raster, checked every clk against a position-from-time reference model.
module tb_vga_frame_source;

  localparam int D0  = 3;
  localparam int HA  = 16, HFP = 2, HS = 3, HB = 3;
  localparam int VA  = 8,  VFP = 2, VS = 2, VB = 1;
  localparam int HT  = HA + HFP + HS + HB;
  localparam int VT  = VA + VFP + VS + VB;
  localparam int FT  = HT * VT;
  localparam int BOUND = 3 * FT * D0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [47:0] din = '0;

  logic [47:0] a_concat, b_concat;
  logic        a_ack, a_pend, a_hs, a_vs, a_de, a_tick, a_fs;
  logic        b_ack, b_pend, b_hs, b_vs, b_de, b_tick, b_fs;
  logic [9:0]  a_sx, a_sy, b_sx, b_sy;

  vga_frame_source #(
    .CLK_DIV(D0), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .numbers_in(din), .numbers_wr(wr),
    .numbers_concat(a_concat), .numbers_ack(a_ack), .numbers_pending(a_pend),
    .sx(a_sx), .sy(a_sy), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .pix_tick(a_tick), .frame_start(a_fs)
  );

  vga_frame_source #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .numbers_in(din), .numbers_wr(wr),
    .numbers_concat(b_concat), .numbers_ack(b_ack), .numbers_pending(b_pend),
    .sx(b_sx), .sy(b_sy), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .pix_tick(b_tick), .frame_start(b_fs)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int t      = 0;
  int ack_cnt = 0;

  logic [47:0] m_concat [2];
  logic [47:0] m_pend   [2];
  bit          m_pending[2];
  bit          m_ack    [2];

  typedef struct {
    int          x;
    int          y;
    bit          at_wrap;
    logic [47:0] data;
    bit          check;
    logic [47:0] exp_concat;
    int          exp_acks;
  } vec_t;
  vec_t tbl[5];

  function automatic int dv(input int k);
    return (k == 0) ? D0 : 1;
  endfunction
  // Pixel positions consumed since reset release; one pixel per d clks.
  function automatic int npix(input int tt, input int d);
    return (tt < 1) ? 0 : (tt - 1) / d;
  endfunction
  function automatic bit tick_of(input int tt, input int d);
    return (tt >= d) && (tt % d == 0);
  endfunction
  function automatic bit fs_of(input int tt, input int d);
    int n = npix(tt, d);
    return (tt >= 1) && ((tt - 1) % d == 0) && (n > 0) && (n % FT == 0);
  endfunction
  function automatic int cur_x();
    return npix(t, D0) % HT;
  endfunction
  function automatic int cur_y();
    return (npix(t, D0) / HT) % VT;
  endfunction

  function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
  endfunction

  function automatic void fail_bound(input string name);
    total++;
    $display("FAIL %s: bound expired (t=%0d)", name, t);
  endfunction

  function automatic void check_dut(input int k, input logic [9:0] sx, input logic [9:0] sy,
      input logic hs, input logic vs, input logic de, input logic tk, input logic fs,
      input logic ack, input logic pend, input logic [47:0] cat);
    int d  = dv(k);
    int n  = npix(t, d);
    int ex = n % HT;
    int ey = (n / HT) % VT;
    bit ehs = !((ex >= HA + HFP) && (ex < HA + HFP + HS));
    bit evs = !((ey >= VA + VFP) && (ey < VA + VFP + VS));
    bit ede = (ex < HA) && (ey < VA);
    chk($sformatf("d%0d_sx", k),      48'(sx),   48'(ex));
    chk($sformatf("d%0d_sy", k),      48'(sy),   48'(ey));
    chk($sformatf("d%0d_hsync", k),   48'(hs),   48'(ehs));
    chk($sformatf("d%0d_vsync", k),   48'(vs),   48'(evs));
    chk($sformatf("d%0d_de", k),      48'(de),   48'(ede));
    chk($sformatf("d%0d_tick", k),    48'(tk),   48'(tick_of(t, d)));
    chk($sformatf("d%0d_fstart", k),  48'(fs),   48'(fs_of(t, d)));
    chk($sformatf("d%0d_ack", k),     48'(ack),  48'(m_ack[k]));
    chk($sformatf("d%0d_pending", k), 48'(pend), 48'(m_pending[k]));
    chk($sformatf("d%0d_concat", k),  cat,       m_concat[k]);
  endfunction

  task automatic step(input bit r, input bit w, input logic [47:0] d);
    rst_n = !r;
    wr    = w;
    din   = d;
    @(posedge clk);
    #1;
    if (r) t = 0;
    else   t++;
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = 1'b0;
      if (r) begin
        m_concat[k] = '0; m_pend[k] = '0; m_pending[k] = 1'b0;
      end else if (fs_of(t, dv(k)) && (w || m_pending[k])) begin
        m_concat[k]  = w ? d : m_pend[k];
        m_pending[k] = 1'b0;
        m_ack[k]     = 1'b1;
      end else if (w) begin
        m_pend[k]    = d;
        m_pending[k] = 1'b1;
      end
    end
    if (a_ack) ack_cnt++;
    check_dut(0, a_sx, a_sy, a_hs, a_vs, a_de, a_tick, a_fs, a_ack, a_pend, a_concat);
    check_dut(1, b_sx, b_sy, b_hs, b_vs, b_de, b_tick, b_fs, b_ack, b_pend, b_concat);
  endtask

  task automatic go_to(input int x, input int y, input bit need_tick);
    int g = 0;
    while (!(cur_x() == x && cur_y() == y && (!need_tick || tick_of(t, D0))) && g < BOUND) begin
      step(1'b0, 1'b0, '0);
      g++;
    end
    if (g >= BOUND) fail_bound("goto");
  endtask

  task automatic wait_fs();
    int g = 0;
    do begin
      step(1'b0, 1'b0, '0);
      g++;
    end while (!a_fs && g < BOUND);
    if (!a_fs) fail_bound("wait_frame_start");
  endtask

  initial begin
    int first_tick;
    int fs1, fs2, fall1, fall2, hs_low, vs_low, de_cnt, max_sy, base;
    logic prev_hs;
    logic [63:0] rnd;

    tbl[0] = '{x: 5,  y: 3,  at_wrap: 0, data: 48'h123456789AB0, check: 1, exp_concat: 48'h123456789AB0, exp_acks: 1};
    tbl[1] = '{x: 2,  y: 1,  at_wrap: 0, data: 48'h111111111111, check: 0, exp_concat: 48'h0,            exp_acks: 0};
    tbl[2] = '{x: 10, y: 5,  at_wrap: 0, data: 48'h222222222222, check: 1, exp_concat: 48'h222222222222, exp_acks: 1};
    tbl[3] = '{x: HT-1, y: VT-1, at_wrap: 1, data: 48'h333333333333, check: 1, exp_concat: 48'h333333333333, exp_acks: 1};
    tbl[4] = '{x: 20, y: 11, at_wrap: 0, data: 48'hFEDCBA987654, check: 1, exp_concat: 48'hFEDCBA987654, exp_acks: 1};

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    chk("reset_sx", 48'(a_sx), 48'd0);
    chk("reset_de", 48'(a_de), 48'd1);

    first_tick = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      if (a_tick && first_tick < 0) first_tick = t;
    end
    chk("first_tick_latency", 48'(first_tick), 48'(D0));

    wait_fs();
    fs1 = -1; fs2 = -1; fall1 = -1; fall2 = -1;
    hs_low = 0; vs_low = 0; de_cnt = 0; max_sy = 0;
    prev_hs = a_hs;
    for (int k = 1; k <= 2 * FT * D0; k++) begin
      step(1'b0, 1'b0, '0);
      if (a_fs) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (prev_hs && !a_hs) begin
        if (fall1 < 0) begin
          fall1 = k;
          chk("hsync_fall_sx", 48'(a_sx), 48'(HA + HFP));
        end else if (fall2 < 0) fall2 = k;
      end
      prev_hs = a_hs;
      if (k <= HT * D0 && !a_hs) hs_low++;
      if (k <= FT * D0) begin
        if (!a_vs) vs_low++;
        if (a_de && a_tick) de_cnt++;
      end
      if (int'(a_sy) > max_sy) max_sy = int'(a_sy);
    end
    chk("frame_period_1", 48'(fs1), 48'(FT * D0));
    chk("frame_period_2", 48'(fs2 - fs1), 48'(FT * D0));
    chk("hsync_period", 48'(fall2 - fall1), 48'(HT * D0));
    chk("hsync_low_clks", 48'(hs_low), 48'(HS * D0));
    chk("vsync_low_clks", 48'(vs_low), 48'(VS * HT * D0));
    chk("de_pixels_frame", 48'(de_cnt), 48'(HA * VA));
    chk("max_sy", 48'(max_sy), 48'(VT - 1));

    base = ack_cnt;
    foreach (tbl[i]) begin
      go_to(tbl[i].x, tbl[i].y, tbl[i].at_wrap);
      step(1'b0, 1'b1, tbl[i].data);
      if (!tbl[i].at_wrap) begin
        chk($sformatf("tbl%0d_pending", i), 48'(a_pend), 48'd1);
        if (tbl[i].check) wait_fs();
      end
      if (tbl[i].check) begin
        chk($sformatf("tbl%0d_fstart", i), 48'(a_fs), 48'd1);
        chk($sformatf("tbl%0d_ack", i), 48'(a_ack), 48'd1);
        chk($sformatf("tbl%0d_concat", i), a_concat, tbl[i].exp_concat);
        chk($sformatf("tbl%0d_pending_clr", i), 48'(a_pend), 48'd0);
        chk($sformatf("tbl%0d_ack_count", i), 48'(ack_cnt - base), 48'(tbl[i].exp_acks));
        base = ack_cnt;
      end
    end

    // Pending word discarded by a mid-frame reset; the next wrap must stay silent.
    go_to(3, 2, 1'b0);
    step(1'b0, 1'b1, 48'hABCDEF012345);
    go_to(12, 7, 1'b0);
    step(1'b1, 1'b0, '0);
    chk("midrst_sx", 48'(a_sx), 48'd0);
    chk("midrst_sy", 48'(a_sy), 48'd0);
    chk("midrst_pending", 48'(a_pend), 48'd0);
    chk("midrst_concat", a_concat, 48'd0);
    base = ack_cnt;
    wait_fs();
    chk("midrst_no_ack", 48'(ack_cnt - base), 48'd0);
    chk("midrst_concat_hold", a_concat, 48'd0);

    for (int i = 0; i < 4000; i++) begin
      rnd = {$urandom(), $urandom()};
      step($urandom_range(0, 999) < 2, $urandom_range(0, 99) < 4, rnd[47:0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
